// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the BCD counter bank.
//   bcd_digit_t   : one packed BCD digit
//   BCD_MAX       : largest legal digit value
//   bcd_inc       : {carry, digit} after adding one to a digit
//   bcd_dec       : {borrow, digit} after subtracting one from a digit
//   bcd_limit_ok  : elaboration-time check that every nibble of a packed
//                   BCD constant is a legal digit
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Widest packed value the bank can be built with: 8 channels x 6 digits.
   localparam int BCD_MAX_NIBBLES = 48;

   function automatic logic [4:0] bcd_inc(input bcd_digit_t d);
      logic [4:0] res;
      if (d >= BCD_MAX) begin
         res = {1'b1, 4'd0};
      end else begin
         res = {1'b0, d + 4'd1};
      end
      return res;
   endfunction

   function automatic logic [4:0] bcd_dec(input bcd_digit_t d);
      logic [4:0] res;
      if (d == 4'd0) begin
         res = {1'b1, BCD_MAX};
      end else begin
         res = {1'b0, d - 4'd1};
      end
      return res;
   endfunction

   function automatic bit bcd_limit_ok(input logic [BCD_MAX_NIBBLES*4-1:0] packed_val,
                                       input int nibbles);
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < BCD_MAX_NIBBLES; k++) begin
         if (k < nibbles && packed_val[k*4 +: 4] > BCD_MAX) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_channel.sv
// One multi-digit BCD counter with a fixed wrap limit.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   ev_i     : step event (already source-selected by the bank)
//   dir_i    : 0 = count up, 1 = count down
//   clr_i    : synchronous clear to zero, overrides ev_i
//   value_o  : packed BCD value, digit 0 in the LSBs
//   wrap_o   : one-cycle registered pulse when the counter wraps
module bcd_channel
   import bcd_pkg::*;
#(
   parameter int                  DIGITS   = 2,
   parameter logic [DIGITS*4-1:0] LIMIT_CH = {DIGITS{4'h9}}
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                ev_i,
   input  logic                dir_i,
   input  logic                clr_i,
   output logic [DIGITS*4-1:0] value_o,
   output logic                wrap_o
);

   localparam int W = DIGITS * 4;

   logic [W-1:0] value_q, value_d;
   logic [W-1:0] inc_val, dec_val;
   logic         wrap_q, wrap_d;

   // Ripple carry through the digits: only digits below the first
   // non-9 digit (plus that digit) change.
   always_comb begin : inc_chain
      logic       carry;
      logic [4:0] r;
      inc_val = value_q;
      carry   = 1'b1;
      r       = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r = bcd_inc(value_q[d*4 +: 4]);
         if (carry) begin
            inc_val[d*4 +: 4] = r[3:0];
         end
         carry = carry & r[4];
      end
   end

   always_comb begin : dec_chain
      logic       borrow;
      logic [4:0] r;
      dec_val = value_q;
      borrow  = 1'b1;
      r       = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r = bcd_dec(value_q[d*4 +: 4]);
         if (borrow) begin
            dec_val[d*4 +: 4] = r[3:0];
         end
         borrow = borrow & r[4];
      end
   end

   // The limit compare comes before the digit chain, so a counter with a
   // limit below all-9s wraps at the limit rather than at digit overflow.
   always_comb begin
      value_d = value_q;
      wrap_d  = 1'b0;
      if (clr_i) begin
         value_d = '0;
      end else if (ev_i) begin
         if (!dir_i) begin
            if (value_q == LIMIT_CH) begin
               value_d = '0;
               wrap_d  = 1'b1;
            end else begin
               value_d = inc_val;
            end
         end else begin
            if (value_q == '0) begin
               value_d = LIMIT_CH;
               wrap_d  = 1'b1;
            end else begin
               value_d = dec_val;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         wrap_q  <= wrap_d;
      end
   end

   assign value_o = value_q;
   assign wrap_o  = wrap_q;

endmodule

// File: rtl/bcd_counter_bank.sv
// Bank of independent BCD counters sharing one pausable prescaler tick.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   inc_i        : per-channel external step pulse
//   src_sel_i    : per-channel step source, 0 = inc_i, 1 = internal tick
//   dir_i        : per-channel direction, 0 = up, 1 = down
//   clr_i        : per-channel synchronous clear
//   run_toggle_i : one-cycle pulse that flips the prescaler run state
//   bcd_o        : packed counter values, channel 0 in the LSBs
//   wrap_o       : per-channel one-cycle wrap pulse
//   tick_o       : registered prescaler tick
//   running_o    : current prescaler run state
module bcd_counter_bank
   import bcd_pkg::*;
#(
   parameter int                           CHANNELS = 3,
   parameter int                           DIGITS   = 2,
   parameter logic [CHANNELS*DIGITS*4-1:0] LIMIT    = {CHANNELS{ {DIGITS{4'h9}} }},
   parameter int                           TICK_MAX = 10000000,
   parameter bit                           RUN_INIT = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [CHANNELS-1:0]          inc_i,
   input  logic [CHANNELS-1:0]          src_sel_i,
   input  logic [CHANNELS-1:0]          dir_i,
   input  logic [CHANNELS-1:0]          clr_i,
   input  logic                         run_toggle_i,
   output logic [CHANNELS*DIGITS*4-1:0] bcd_o,
   output logic [CHANNELS-1:0]          wrap_o,
   output logic                         tick_o,
   output logic                         running_o
);

   localparam int CH_W = DIGITS * 4;
   localparam int CNT_W = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX - 1);
   localparam bit LIMIT_OK = bcd_limit_ok((BCD_MAX_NIBBLES*4)'(LIMIT), CHANNELS * DIGITS);

   if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("bcd_counter_bank: CHANNELS must be 1..8");
   end
   if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
      $error("bcd_counter_bank: DIGITS must be 1..6");
   end
   if (TICK_MAX < 2) begin : g_bad_tick
      $error("bcd_counter_bank: TICK_MAX must be at least 2");
   end
   if (!LIMIT_OK) begin : g_bad_limit
      $error("bcd_counter_bank: every LIMIT nibble must be a BCD digit");
   end

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tick_q, tick_d;
   logic                running_q, running_d;
   logic [CHANNELS-1:0] ev;

   // A toggle on the terminal-count edge still lets that tick out because
   // the prescaler looks at running_q, not running_d.
   always_comb begin
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      running_d = running_q ^ run_toggle_i;
      if (running_q) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         running_q <= RUN_INIT;
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         running_q <= running_d;
      end
   end

   // The registered tick is the event, so tick-driven channels move one
   // cycle after tick_o rises.
   assign ev = (src_sel_i & {CHANNELS{tick_q}}) | (~src_sel_i & inc_i);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      bcd_channel #(
         .DIGITS   (DIGITS),
         .LIMIT_CH (LIMIT[i*CH_W +: CH_W])
      ) u_chan (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .ev_i    (ev[i]),
         .dir_i   (dir_i[i]),
         .clr_i   (clr_i[i]),
         .value_o (bcd_o[i*CH_W +: CH_W]),
         .wrap_o  (wrap_o[i])
      );
   end

   assign tick_o    = tick_q;
   assign running_o = running_q;

endmodule

// File: doc/bcd_counter_bank.md
Name: bcd_counter_bank

Overview:
- Parametrised bank of CHANNELS independent multi-digit BCD counters, each with its own packed-BCD wrap limit, up/down direction and synchronous clear.
- Each channel is stepped by either an external one-cycle pulse (debounced button flag) or a shared internal tick from a pausable prescaler.
- Packed BCD outputs feed the per-digit display encoders and the LED scan controller.
- Next generation of the fixed two-digit counter set: adds arbitrary digit count, per-channel limits, down-counting, clear, wrap pulses and a run/pause-controlled tick source.

Parameters:
- CHANNELS, 3, number of counter channels (1..8).
- DIGITS, 2, BCD digits per channel (1..6).
- LIMIT, {CHANNELS{ {DIGITS{4'h9}} }}, packed BCD wrap value per channel, CHANNELS*DIGITS*4 bits; channel 0 in the LSBs; every nibble must be ≤9, else elaboration error.
- TICK_MAX, 10000000, prescaler period in clk cycles (≥2).
- RUN_INIT, 1, running state after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- inc  in  CHANNELS  per-channel external step pulse, one cycle wide.
- src_sel  in  CHANNELS  per-channel step source: 0 = inc, 1 = internal tick.
- dir  in  CHANNELS  per-channel direction: 0 = up, 1 = down.
- clr  in  CHANNELS  per-channel synchronous clear to 0.
- run_toggle  in  1  one-cycle pulse; flips the prescaler run state.
- bcd  out  CHANNELS*DIGITS*4  packed counter values, channel 0 in the LSBs, digit 0 in the LSBs of each channel.
- wrap  out  CHANNELS  one-cycle registered pulse when a channel wraps.
- tick  out  1  registered prescaler tick.
- running  out  1  current run state.

Behaviour:
- Reset, asynchronous while rst=0:
  - bcd=0, wrap=0, tick=0, prescaler=0, running=RUN_INIT.
- Prescaler:
  - While running=1, counts 0..TICK_MAX-1.
  - On the edge where the count equals TICK_MAX-1, it returns to 0 and tick is registered high for exactly one cycle.
  - While running=0, the count holds and tick=0.
- run_toggle:
  - running flips on the sampled edge.
  - A tick generated on that same edge is still issued.
  - The change affects only subsequent cycles.
- Step event per channel: ev[i] = src_sel[i] ? tick : inc[i].
  - tick is used as registered, so tick-driven channels update one cycle after tick rises.
- Per-channel update, evaluated on each rising clk edge:
  - clr[i]=1: value←0, wrap[i]=0. Clear overrides ev.
  - ev[i]=1 and dir[i]=0:
    - If value==LIMIT[i]: value←0, wrap[i]←1.
    - Otherwise BCD increment: a digit at 9 becomes 0 and carries into the next digit.
  - ev[i]=1 and dir[i]=1:
    - If value==0: value←LIMIT[i], wrap[i]←1.
    - Otherwise BCD decrement: a digit at 0 becomes 9 and borrows from the next digit.
  - Otherwise: value holds, wrap[i]←0.
- Latency: bcd and wrap reflect an event on the cycle after it is sampled; no combinational path from inputs to outputs.
- Invariants:
  - Value never exceeds LIMIT[i].
  - Every nibble is always ≤9.
  - Changing dir mid-count takes effect on the next event with no glitch.
- Event spacing: consecutive-cycle events are each counted; inc held high counts once per cycle.
- Reset mid-count: the asynchronous clear dominates; counting resumes from 0 after rst deasserts, with the prescaler phase restarted.

Decomposition:
- Shared package bcd_pkg:
  - bcd_digit_t (4-bit).
  - BCD_MAX=4'd9.
  - Helper functions bcd_inc / bcd_dec returning {carry, digit}.
- Sub-module bcd_channel:
  - One counter with parameters DIGITS and LIMIT_CH.
  - Inputs ev, dir, clr; outputs value and wrap.
  - Instantiated CHANNELS times via generate.
- The prescaler and run state stay in bcd_counter_bank.

Test Plan:
- CHANNELS=3, DIGITS=2, LIMIT={8'h05, 8'h99, 8'h29} (channels 2..0), TICK_MAX=4.
- Ch0 up, src_sel=0: 30 inc pulses → bcd ch0 goes 00..29 then 00; wrap[0] high for exactly one cycle on the 30th pulse; carry 09→10 and 19→20 checked.
- Ch1 down from reset: one inc → 99 with wrap[1]; then 10 more pulses → 89.
- Ch2 src_sel=1, running=1: tick every 4 cycles; after 24 cycles ch2=05, at the 6th tick ch2=00 with wrap[2]. Then pulse run_toggle: tick stays 0 for 20 cycles and ch2 holds. Toggle again: tick resumes from the held phase.
- clr[0] and inc[0] in the same cycle with ch0=17 → ch0=00, wrap[0]=0.
- Flip dir[1] between consecutive pulses at 50 → 51 then 50; back-to-back inc on 3 consecutive cycles → 3 counts.
- Assert rst=0 asynchronously mid-cycle with ch0=12 and prescaler=2 → all outputs 0 immediately; running=RUN_INIT; after release the first tick arrives 4 cycles later.
